fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage. Owns the PC and issues requests on the instruction bus.
//  Buffers each returned word and presents {pc, instruction} to the decode stage with a valid/ready handshake.
//  Accepts PC redirects (jump target) computed by decode.
//  Producer end of the fetch->decode interface; decode is the consumer.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000   PC of the first fetch after reset
//  PC_STEP    4               byte increment for sequential fetch
// PORTS
//  clk            in   1    clock, all state on rising edge
//  reset          in   1    asynchronous, active-high reset
//  ireq_valid     out  1    instruction-bus request valid
//  ireq_addr      out  32   request address (word aligned)
//  iresp_addr_ok  in   1    bus accepted address this cycle
//  iresp_data_ok  in   1    iresp_data valid this cycle
//  iresp_data     in   32   instruction word
//  fetch_valid    out  1    fetch_data holds an undelivered instruction
//  fetch_ready    in   1    decode accepts fetch_data this cycle (= decode_enable)
//  fetch_data     out  64   fetch_data_t {pc, instruction}
//  redirect_valid in   1    redirect next fetch to redirect_pc
//  redirect_pc    in   32   jump/branch target, bits[1:0] ignored (forced 0)
// BEHAVIOUR
//  Reset state (async):
//   - pc=RESET_PC, state=REQ, ireq_valid=0 during reset.
//   - fetch_valid=0, fetch_data=0, pend_redir=0.
//  FSM:
//   - REQ:
//     - ireq_valid=1, ireq_addr=pc.
//     - ireq_addr is held stable until addr_ok.
//     - On addr_ok go to WAIT.
//     - If data_ok arrives in the same cycle as addr_ok, go straight to OUT.
//   - WAIT:
//     - ireq_valid=0.
//     - On data_ok, capture {pc, iresp_data} into fetch_data and go to OUT.
//   - OUT:
//     - fetch_valid=1; fetch_data is stable while fetch_valid && !fetch_ready.
//     - On fetch_ready, fetch_valid drops next cycle, pc advances by PC_STEP and state goes to REQ.
//  Latency and throughput:
//   - Zero-wait bus (addr_ok in REQ cycle, data_ok next cycle): fetch_valid asserts 2 cycles after the REQ cycle.
//   - Throughput is 1 instruction per 3 cycles. No overlap of requests; at most one request is outstanding.
//  Redirect (latest redirect_pc always wins):
//   - In REQ before addr_ok: the address cannot change.
//     - Set pend_redir and latch the target.
//     - Complete the transaction and discard its data (no OUT).
//     - Then go to REQ at the target.
//   - In WAIT: same as above; the in-flight word is dropped.
//   - In OUT without fetch_ready: the buffered word is dropped (fetch_valid=0 next cycle).
//     pc=target, state goes to REQ.
//   - In OUT with fetch_ready in the same cycle: the word is delivered (delay slot preserved).
//     The next pc is the target, not pc+PC_STEP.
//   - Redirect in the same cycle as a discarded data_ok: the new target replaces the latched one.
//     Go to REQ at the new target.
//   - Several redirects before resolution: the last one is used.
//  Width rules:
//   - pc arithmetic is modulo 2^32 (0xFFFF_FFFC + 4 -> 0).
//   - ireq_addr[1:0] is always 2'b00.
//  Reset mid-operation:
//   - All state returns to reset values immediately; any outstanding response is ignored.
//   - The bus is reset by the same reset.
//  data_ok in REQ without addr_ok, or in OUT, is a protocol violation. A bench assertion flags it.
// STRUCTURE
//  pipes package:
//   - fetch_data_t {u32 pc; u32 instruction} (already shared with decode).
//   - fetch_state_t enum {F_REQ, F_WAIT, F_OUT}.
//  common package: u32 and the ibus request/response field widths.
//  Sub-module pc_reg: PC register plus next-pc mux (redirect / pending / +PC_STEP / hold).
//  FSM, response buffer and pend_redir logic sit in fetch_unit.
// TESTING
//  1. Reset, zero-wait bus, fetch_ready=1.
//     -> addrs BFC0_0000, BFC0_0004, BFC0_0008 are issued.
//     -> fetch_data.pc matches each addr; one delivery every 3 cycles.
//  2. fetch_ready=0 for 5 cycles in OUT.
//     -> fetch_valid stays 1, fetch_data is unchanged, no new ireq_valid.
//     -> Raise ready: the next request is to pc+4.
//  3. redirect_valid with redirect_pc=0x8000_0100 while in WAIT.
//     -> The returned word is dropped; fetch_valid is never raised for it.
//     -> The next ireq_addr is 0x8000_0100.
//  4. redirect_pc=0x8000_0200 together with fetch_ready in OUT.
//     -> The current word is delivered and the next ireq_addr is 0x8000_0200.
//  5. Two redirects (0x100, then 0x200) in consecutive cycles while addr_ok is stalled 4 cycles.
//     -> The original address is held stable until addr_ok.
//     -> The response is discarded and the next ireq_addr is 0x200.
//  6. Reset asserted while in WAIT.
//     -> fetch_valid=0 and ireq_valid=0 at once.
//     -> After release, the first ireq_addr is BFC0_0000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// =============================================================================
// Module  : fetch_unit_pkg
// Brief   : Shared types for the fetch stage and the fetch->decode interface.
// Revision: 1.0 - initial release
// =============================================================================
package fetch_unit_pkg;

    localparam int IBUS_ADDR_W = 32;
    localparam int IBUS_DATA_W = 32;

    typedef logic [31:0] u32;

    typedef struct packed {
        u32 pc;
        u32 instruction;
    } fetch_data_t;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_OUT  = 2'd2
    } fetch_state_t;

    function automatic u32 word_align(input u32 a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_pc_reg.sv
`default_nettype none
// =============================================================================
// Module  : fetch_unit_pc_reg
// Brief   : Program counter with next-pc selection (redirect/pending/step/hold).
// Revision: 1.0 - initial release
// =============================================================================
module fetch_unit_pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_take_redir,
    input  logic        i_take_pend,
    input  logic        i_advance,
    input  logic [31:0] i_redir_pc,
    input  logic [31:0] i_pend_pc,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;

    // A live redirect always beats a latched one.
    always_comb begin
        w_pc_next = r_pc;
        if (i_take_redir) begin
            w_pc_next = word_align(i_redir_pc);
        end else if (i_take_pend) begin
            w_pc_next = i_pend_pc;
        end else if (i_advance) begin
            w_pc_next = r_pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// Module  : fetch_unit
// Brief   : Instruction fetch stage: one outstanding bus request, buffered word,
//           valid/ready hand-off to decode, redirect handling.
// Revision: 1.0 - initial release
// =============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   ireq_valid,
    output logic [IBUS_ADDR_W-1:0] ireq_addr,
    input  logic                   iresp_addr_ok,
    input  logic                   iresp_data_ok,
    input  logic [IBUS_DATA_W-1:0] iresp_data,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [63:0]            fetch_data,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic         r_pend;
    u32           r_pend_pc;
    fetch_data_t  r_fetch_data;
    u32           w_pc;
    logic         w_resp;
    logic         w_set_pend;
    logic         w_clr_pend;
    logic         w_capture;
    logic         w_take_redir;
    logic         w_take_pend;
    logic         w_advance;

    fetch_unit_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk          (clk),
        .rst          (reset),
        .i_take_redir (w_take_redir),
        .i_take_pend  (w_take_pend),
        .i_advance    (w_advance),
        .i_redir_pc   (redirect_pc),
        .i_pend_pc    (r_pend_pc),
        .o_pc         (w_pc)
    );

    always_comb begin
        w_state_next = r_state;
        w_set_pend   = 1'b0;
        w_clr_pend   = 1'b0;
        w_capture    = 1'b0;
        w_take_redir = 1'b0;
        w_take_pend  = 1'b0;
        w_advance    = 1'b0;
        w_resp       = iresp_data_ok &&
                       ((r_state == F_WAIT) || ((r_state == F_REQ) && iresp_addr_ok));

        case (r_state)
            F_REQ: begin
                if (iresp_addr_ok) begin
                    w_state_next = F_WAIT;
                end
            end
            F_WAIT: begin
                w_state_next = F_WAIT;
            end
            F_OUT: begin
                if (redirect_valid) begin
                    w_take_redir = 1'b1;
                    w_state_next = F_REQ;
                end else if (fetch_ready) begin
                    w_advance    = 1'b1;
                    w_state_next = F_REQ;
                end
            end
            default: begin
                w_state_next = F_REQ;
            end
        endcase

        // While a request is in flight its address is frozen, so a redirect
        // is parked and resolved once the (then useless) response returns.
        if (r_state != F_OUT) begin
            if (w_resp) begin
                if (redirect_valid) begin
                    w_take_redir = 1'b1;
                    w_clr_pend   = 1'b1;
                    w_state_next = F_REQ;
                end else if (r_pend) begin
                    w_take_pend  = 1'b1;
                    w_clr_pend   = 1'b1;
                    w_state_next = F_REQ;
                end else begin
                    w_capture    = 1'b1;
                    w_state_next = F_OUT;
                end
            end else if (redirect_valid) begin
                w_set_pend = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= F_REQ;
            r_pend       <= 1'b0;
            r_pend_pc    <= '0;
            r_fetch_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_set_pend) begin
                r_pend    <= 1'b1;
                r_pend_pc <= word_align(redirect_pc);
            end else if (w_clr_pend) begin
                r_pend <= 1'b0;
            end
            if (w_capture) begin
                r_fetch_data <= '{pc: w_pc, instruction: iresp_data};
            end
        end
    end

    assign ireq_valid  = (r_state == F_REQ) && !reset;
    assign ireq_addr   = word_align(w_pc);
    assign fetch_valid = (r_state == F_OUT);
    assign fetch_data  = r_fetch_data;

endmodule
`default_nettype wire
